// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NREQ producers share one FIFO write port.
// The arbiter grants one owner at a time for up to BURST writes, then rotates.
// Acks and FIFO writes are combinational, so a word is taken in the same
// cycle it is requested.
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int BITWIDTH = 5,
    parameter int BURST    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*BITWIDTH-1:0] dInFlat,
    output logic [NREQ-1:0]          ack,
    input  logic                     fifoFull,
    output logic                     fifoWEn,
    output logic [BITWIDTH-1:0]      fifoDIn,
    output logic [IDW-1:0]           ownerId,
    output logic                     busy,
    output logic [15:0]              wrCount
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] owner, owner_nxt;
    logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
    logic [7:0]     burst_cnt, burst_cnt_nxt;
    logic [IDW-1:0] pick, cand;
    logic           wr;

    // Index arithmetic wraps at NREQ, which need not be a power of two.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Round-robin pick: first requester at or after rr_ptr. The loop runs
    // backwards so the closest requester is the last one assigned.
    always_comb begin
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap_add(rr_ptr, k)]) pick = wrap_add(rr_ptr, k);
        end
    end

    // Write path: the current owner, or the fresh pick in IDLE. Never write
    // while full or in reset.
    always_comb begin
        cand    = (state == OWN) ? owner : pick;
        wr      = req[cand] & ~fifoFull & ~rst;
        ack     = '0;
        fifoWEn = wr;
        fifoDIn = '0;
        if (wr) begin
            ack[cand] = 1'b1;
            fifoDIn   = dInFlat[int'(cand)*BITWIDTH +: BITWIDTH];
        end
    end

    // Ownership FSM: grant, count the burst, rotate on burst end or release.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    owner_nxt     = pick;
                    burst_cnt_nxt = {7'b0, wr};
                    // A single-write burst completes on the grant cycle itself.
                    if (wr && BURST == 1) rr_ptr_nxt = wrap_add(pick, 1);
                    else                  state_nxt  = OWN;
                end
            end
            OWN: begin
                if (!req[owner]) begin
                    // The owner dropped its request and forfeits the rest of the burst.
                    state_nxt  = IDLE;
                    rr_ptr_nxt = wrap_add(owner, 1);
                end else if (wr) begin
                    if (burst_cnt + 8'd1 == 8'(BURST)) begin
                        state_nxt     = IDLE;
                        rr_ptr_nxt    = wrap_add(owner, 1);
                        burst_cnt_nxt = '0;
                    end else begin
                        burst_cnt_nxt = burst_cnt + 8'd1;
                    end
                end
                // When the owner is requesting but the FIFO is full: stall, holding everything.
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State registers and the free-running accepted-write counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            wrCount   <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            if (wr) wrCount <= wrCount + 16'd1;
        end
    end

    assign ownerId = owner;
    assign busy    = (state == OWN);

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that lets NREQ independent producers share the write port of one synchronous FIFO.
- Each producer presents data with a request/acknowledge handshake. The arbiter grants one owner at a time for a burst of up to BURST writes, then rotates ownership.
- Sits directly in front of the FIFO's wEn/dIn/full interface. The FIFO read side is untouched.

Parameters:
- NREQ, 4, number of requesters.
- IDW, 2, owner-index width; must satisfy 2**IDW >= NREQ.
- BITWIDTH, 5, data width; matches the FIFO's BITWIDTH.
- BURST, 4, maximum consecutive writes per ownership; legal range 1..2**8-1.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst, input, 1, synchronous active-high reset.
- req, input, NREQ, per-requester request; held high with data stable until acked.
- dInFlat, input, NREQ*BITWIDTH, packed data; requester i occupies bits [i*BITWIDTH +: BITWIDTH].
- ack, output, NREQ, combinational one-hot; the word of requester i is written this cycle.
- fifoFull, input, 1, FIFO full flag.
- fifoWEn, output, 1, FIFO write enable, combinational.
- fifoDIn, output, BITWIDTH, FIFO write data, combinational.
- ownerId, output, IDW, registered current or last owner index.
- busy, output, 1, registered; 1 while in state OWN.
- wrCount, output, 16, registered total accepted writes; wraps 0xFFFF->0.

Behaviour:
- State registers: state {IDLE, OWN}, owner (IDW bits), rrPtr (IDW bits, next search start), burstCnt (8 bits), wrCount.
- Reset (rst=1 at posedge): state=IDLE, owner=0, rrPtr=0, burstCnt=0, wrCount=0.
- While rst=1, ack=0, fifoWEn=0 and fifoDIn=0 combinationally, regardless of req.
- Pick (combinational): the first i with req[i]=1, searching rrPtr, rrPtr+1, ... modulo NREQ.
- Candidate: in IDLE, cand = pick; in OWN, cand = owner.
- Write condition: wr = req[cand] & !fifoFull & !rst. Writes are never issued while full, even if the FIFO is being read the same cycle.
- When wr=1: fifoWEn=1, fifoDIn=dIn of cand, ack[cand]=1, all other acks 0. This is zero-latency: the ack and the write occur in the same cycle as the request.
- When wr=0: fifoWEn=0, ack=0, fifoDIn=0.
- IDLE:
  - No req: stay in IDLE.
  - Any req: owner<=pick, burstCnt<=wr.
    - If wr=1 and BURST==1: stay IDLE, rrPtr<=pick+1 (mod NREQ).
    - Otherwise: go to OWN.
- OWN:
  - req[owner]=0: release, go IDLE, rrPtr<=owner+1. No write this cycle.
  - req[owner]=1, fifoFull=1: stall. Stay in OWN, burstCnt unchanged, no ack.
  - wr=1 and burstCnt+1==BURST: write, go IDLE, rrPtr<=owner+1, burstCnt<=0.
  - wr=1 otherwise: write, burstCnt<=burstCnt+1.
- wrCount increments by 1 on every cycle with wr=1.
- ownerId reflects the owner register; busy = (state==OWN).
- Modulo wrap: rrPtr and owner+1 wrap NREQ-1 -> 0. This also holds when NREQ is not a power of two.
- Simultaneous requests: only the candidate is acked. Others wait with req held; no starvation, because rotation happens after at most BURST writes or on release.
- A requester dropping req mid-burst forfeits the remainder of its burst.
- Reset mid-burst: the next cycle is IDLE with rrPtr=0. The interrupted requester gets no ack during reset and must keep req/data held.

Test Plan:
- Single requester: req=4'b0001 for 6 cycles, data 1..6, fifoFull=0 (requester advances data on each ack).
  - ack[0] high on 6 consecutive cycles, with data 1,2,3,4 then 5,6.
  - Release to IDLE after the 4th write; re-grant to requester 0 the same cycle in IDLE.
  - wrCount=6.
- All four requesting continuously, BURST=4:
  - Write order is 4 writes from 0, 4 from 1, 4 from 2, 4 from 3, then 0 again.
  - ownerId sequence 0,1,2,3,0; exactly one ack bit per cycle.
- Full stall: owner 2 mid-burst with burstCnt=1, fifoFull=1 for 3 cycles.
  - fifoWEn=0, ack=0, busy=1, ownerId=2 throughout.
  - After full deasserts, 3 more writes complete the burst, then rotation to requester 3.
- Early release: owner 1 drops req after 2 writes while req[3]=1.
  - Next cycle is IDLE with rrPtr=2; requester 3 is granted and written that cycle.
- Reset mid-operation: assert rst for 1 cycle during a burst of owner 3.
  - ack=0 and fifoWEn=0 during reset; afterwards wrCount=0 and busy=0.
  - With req=4'b1010, the first grant goes to requester 1 (rrPtr=0).
- wrCount wrap: preload 0xFFFE writes (or force) plus 3 writes -> wrCount=1.
